// File: rtl/led_pwm_pkg.sv
// Shared constants for the LED output stage: config register selects,
// reset values of the active settings and the common config-ID width.
package led_pkg;

  // Config register select values
  localparam logic CFG_SEL_DUTY  = 1'b0;
  localparam logic CFG_SEL_BLINK = 1'b1;

  // Reset fill bits: duty resets to all-ones (full on), mask to zero (no blink)
  localparam logic DUTY_RST_BIT = 1'b1;
  localparam logic MASK_RST_BIT = 1'b0;

  // Config-ID width shared with the other ALPACACORN register blocks
  localparam int ALPACACORN_ID_W = 8;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_pwm_if.sv
// Configuration write port: valid/ready handshake with a register select.
interface led_pwm_cfg_if #(
  parameter int DATA_W = 8
) ();
  logic              cfg_valid_i;
  logic              cfg_ready_o;
  logic              cfg_sel_i;
  logic [DATA_W-1:0] cfg_data_i;

  modport master (output cfg_valid_i, output cfg_sel_i, output cfg_data_i, input cfg_ready_o);
  modport slave  (input cfg_valid_i, input cfg_sel_i, input cfg_data_i, output cfg_ready_o);
endinterface

// File: rtl/led_pwm_timebase.sv
// PWM period counter plus the blink half-phase counter that advances once
// per PWM period.
module led_pwm_timebase #(
  parameter int PWM_BITS      = 8,
  parameter int BLINK_PERIODS = 65536
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic [PWM_BITS-1:0] cnt,
  output logic                boundary,
  output logic                phase
);

  localparam int BC_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_PERIODS - 1);

  logic [BC_W-1:0] blink_cnt;

  // Last cycle of the PWM period; every period-aligned update happens on its edge
  assign boundary = (cnt == '1);

  // Free-running PWM counter; blink counter steps on each boundary and flips phase at wrap
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      if (boundary) begin
        if (blink_cnt == BC_LAST) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/led_pwm.sv
// LED pad driver: global brightness PWM and per-LED blink mask applied to
// the pattern from the led block. Settings and pattern only change at PWM
// period boundaries so the pads never glitch mid-period.
module led_pwm #(
  parameter int WIDTH         = 7,
  parameter int PWM_BITS      = 8,
  parameter int BLINK_PERIODS = 65536
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] led_i,
  led_pwm_cfg_if.slave     cfg,
  output logic [WIDTH-1:0] led_o,
  output logic             pwm_sync_o
);
  import led_pkg::*;

  localparam int CFG_W = max_w(PWM_BITS, WIDTH);

  logic [PWM_BITS-1:0] cnt;
  logic                boundary;
  logic                phase;

  logic                stage_pend;
  logic                stage_sel;
  logic [CFG_W-1:0]    stage_data;
  logic                accept;

  logic [PWM_BITS-1:0] duty_q;
  logic [WIDTH-1:0]    mask_q;
  logic [WIDTH-1:0]    pat_q;
  logic                pwm_on;
  logic [WIDTH-1:0]    on;

  led_pwm_timebase #(
    .PWM_BITS      (PWM_BITS),
    .BLINK_PERIODS (BLINK_PERIODS)
  ) u_timebase (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .cnt      (cnt),
    .boundary (boundary),
    .phase    (phase)
  );

  // Ready is forced high while in reset so the port reads idle immediately
  assign cfg.cfg_ready_o = ~stage_pend | ~rst_ni;
  assign accept          = cfg.cfg_valid_i & cfg.cfg_ready_o;

  // Single staging slot: filled on accept, drained on the next boundary edge.
  // A write accepted in a boundary cycle is not yet pending on that edge, so
  // it naturally waits one more period.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stage_pend <= 1'b0;
      stage_sel  <= CFG_SEL_DUTY;
      stage_data <= '0;
    end else if (stage_pend) begin
      if (boundary) stage_pend <= 1'b0;
    end else if (accept) begin
      stage_pend <= 1'b1;
      stage_sel  <= cfg.cfg_sel_i;
      stage_data <= cfg.cfg_data_i;
    end
  end

  // Active settings and pattern switch over together on the boundary edge
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      duty_q <= {PWM_BITS{DUTY_RST_BIT}};
      mask_q <= {WIDTH{MASK_RST_BIT}};
      pat_q  <= '0;
    end else if (boundary) begin
      pat_q <= led_i;
      if (stage_pend) begin
        if (stage_sel == CFG_SEL_BLINK) mask_q <= stage_data[WIDTH-1:0];
        else                            duty_q <= stage_data[PWM_BITS-1:0];
      end
    end
  end

  // All-ones duty means constantly on, otherwise lit for the first duty_q counts
  assign pwm_on = (duty_q == '1) || (cnt < duty_q);
  assign on     = pat_q & {WIDTH{pwm_on}} & (~mask_q | {WIDTH{phase}});

  // Registered pad drive; sync marks the output cycle carrying cnt == 0
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      led_o      <= '0;
      pwm_sync_o <= 1'b0;
    end else begin
      led_o      <= on;
      pwm_sync_o <= (cnt == '0);
    end
  end

endmodule
